// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift-register command sequencer.
// Holds command opcodes, register mode selects and FSM state codes.
// Also holds default widths and a small opcode helper.
package shift_sequencer_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNTW  = 3;

  // Command opcodes as seen on cmd_op
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROR  = 2'b11
  } op_t;

  // Mode selects understood by Shift_Register on its s input
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EXEC    = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESP    = 2'b11
  } state_t;

  // A LOAD always needs exactly one register cycle; shifts need cnt cycles
  function automatic logic needs_exec(input op_t op, input logic cnt_nonzero);
    return (op == OP_LOAD) || cnt_nonzero;
  endfunction

endpackage

// File: rtl/Shift_Register.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Updates on the falling edge; output is the registered contents.
// Async active-high reset clears the contents.
module Shift_Register #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] i,
  input  logic             r,
  output logic [WIDTH-1:0] o
);

  // Register update selected by the mode input; serial bit enters MSB on right, LSB on left
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      o <= '0;
    end else begin
      case (s)
        2'b01:   o <= {r, o[WIDTH-1:1]};
        2'b10:   o <= {o[WIDTH-2:0], r};
        2'b11:   o <= i;
        default: o <= o;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer_step_counter.sv
// Loadable down-counter tracking remaining shift steps, with zero flag.
// Load takes priority over decrement; decrement saturates at zero.
// Falling-edge flops, async active-high reset to zero.
module shift_sequencer_step_counter #(
  parameter int CNTW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [CNTW-1:0] load_val,
  input  logic            dec,
  output logic [CNTW-1:0] count,
  output logic            zero
);

  // Load a new step budget or count down one step, never wrapping below zero
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer driving Shift_Register: LOAD / SHR / SHL / ROR by N steps.
// Latency: response valid after edge N+1 past accept (N=1 for LOAD, N=cnt for shifts).
// One command in flight; cmd_ready only when idle, result held until rsp_ready.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNTW-1:0]  cmd_cnt,
  input  logic             cmd_fill,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [1:0]       sr_s,
  output logic [WIDTH-1:0] sr_i,
  output logic             sr_ser,
  input  logic [WIDTH-1:0] sr_o
);

  state_t           state;
  state_t           state_nxt;
  op_t              op_q;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  mode_t            mode;

  logic             cmd_take;
  logic             rsp_take;
  logic             cnt_load;
  logic [CNTW-1:0]  cnt_load_val;
  logic             cnt_dec;
  logic [CNTW-1:0]  step_cnt;
  logic             step_zero;
  logic             step_last;

  shift_sequencer_step_counter #(
    .CNTW (CNTW)
  ) u_step_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (step_cnt),
    .zero     (step_zero)
  );

  // The final EXEC cycle is the one whose edge brings the counter to zero
  assign step_last = step_zero || (step_cnt == CNTW'(1));

  // LOAD is executed as a single register cycle, so it loads a budget of one
  assign cnt_load_val = (op_t'(cmd_op) == OP_LOAD) ? CNTW'(1) : cmd_cnt;

  // State register
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle register controls
  always_comb begin
    state_nxt = state;
    mode      = MODE_HOLD;
    sr_i      = '0;
    sr_ser    = 1'b0;
    cmd_take  = 1'b0;
    rsp_take  = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_take = 1'b1;
          cnt_load = 1'b1;
          if (needs_exec(op_t'(cmd_op), cmd_cnt != '0)) begin
            state_nxt = ST_EXEC;
          end else begin
            state_nxt = ST_CAPTURE;
          end
        end
      end
      ST_EXEC: begin
        cnt_dec = 1'b1;
        unique case (op_q)
          OP_LOAD: begin
            mode = MODE_LOAD;
            sr_i = data_q;
          end
          OP_SHR: begin
            mode   = MODE_SHR;
            sr_ser = fill_q;
          end
          OP_SHL: begin
            mode   = MODE_SHL;
            sr_ser = fill_q;
          end
          OP_ROR: begin
            // Rotation feeds the outgoing LSB straight back into the MSB
            mode   = MODE_SHR;
            sr_ser = sr_o[0];
          end
          default: mode = MODE_HOLD;
        endcase
        if (step_last) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        rsp_take  = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, written only on the accept edge
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_LOAD;
      data_q <= '0;
      fill_q <= 1'b0;
    end else if (cmd_take) begin
      op_q   <= op_t'(cmd_op);
      data_q <= cmd_data;
      fill_q <= cmd_fill;
    end
  end

  // Response register, sampled from the register once it has settled in CAPTURE
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      rsp_data <= '0;
    end else if (rsp_take) begin
      rsp_data <= sr_o;
    end
  end

  assign sr_s      = mode;
  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: shift_sequencer driving a Shift_Register instance.
// Inputs change and outputs are sampled on the rising edge, away from the active falling edge.
module tb_shift_sequencer;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_cnt;
  logic       cmd_fill;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       busy;
  logic [1:0] sr_s;
  logic [3:0] sr_i;
  logic       sr_ser;
  logic [3:0] sr_o;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(
    .WIDTH (4),
    .CNTW  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_cnt   (cmd_cnt),
    .cmd_fill  (cmd_fill),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .sr_s      (sr_s),
    .sr_i      (sr_i),
    .sr_ser    (sr_ser),
    .sr_o      (sr_o)
  );

  Shift_Register #(
    .WIDTH (4)
  ) u_sr (
    .clk   (clk),
    .reset (reset),
    .s     (sr_s),
    .i     (sr_i),
    .r     (sr_ser),
    .o     (sr_o)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, count mode cycles until the response, check and consume it
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] data,
                         input logic [2:0] cnt, input logic fill, input logic [1:0] exp_mode,
                         input int exp_steps, input logic [3:0] exp_rsp);
    int steps;
    int cyc;
    int ser_bad;
    int load_bad;
    steps = 0;
    cyc = 0;
    ser_bad = 0;
    load_bad = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_cnt   = cnt;
    cmd_fill  = fill;
    @(posedge clk);
    cmd_valid = 1'b0;
    while (!rsp_valid && cyc < 40) begin
      if (sr_s === exp_mode) steps++;
      if (op != 2'b00 && sr_s === 2'b11) load_bad++;
      if (op == 2'b11 && sr_s === 2'b01 && sr_ser !== sr_o[0]) ser_bad++;
      if ((op == 2'b01 || op == 2'b10) && sr_s === exp_mode && sr_ser !== fill) ser_bad++;
      cyc++;
      @(posedge clk);
    end
    check({tag, "_steps"}, steps, exp_steps);
    check({tag, "_latency"}, cyc, exp_steps + 1);
    check({tag, "_ser"}, ser_bad, 0);
    check({tag, "_noload"}, load_bad, 0);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 1);
    check({tag, "_rsp_data"}, {28'b0, rsp_data}, {28'b0, exp_rsp});
    check({tag, "_ready_low"}, {31'b0, cmd_ready}, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    rsp_ready = 1'b0;
    check({tag, "_idle_ready"}, {31'b0, cmd_ready}, 1);
    check({tag, "_idle_valid"}, {31'b0, rsp_valid}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 1);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 0);
    check({tag, "_rsp_data"}, {28'b0, rsp_data}, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_sr_s"}, {30'b0, sr_s}, 0);
    check({tag, "_sr_i"}, {28'b0, sr_i}, 0);
    check({tag, "_sr_ser"}, {31'b0, sr_ser}, 0);
    check({tag, "_count"}, {29'b0, dut.step_cnt}, 0);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'b0000;
    cmd_cnt   = 3'd0;
    cmd_fill  = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk);

    // LOAD 1011, stepped by hand: one LOAD cycle, CAPTURE, then RESP after E2
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 4'b1011;
    @(posedge clk);
    cmd_valid = 1'b0;
    check("load_e0_ready", {31'b0, cmd_ready}, 0);
    check("load_e0_busy", {31'b0, busy}, 1);
    check("load_e0_sr_s", {30'b0, sr_s}, 2'b11);
    check("load_e0_sr_i", {28'b0, sr_i}, 4'b1011);
    @(posedge clk);
    check("load_e1_sr_s", {30'b0, sr_s}, 2'b00);
    check("load_e1_sr_o", {28'b0, sr_o}, 4'b1011);
    check("load_e1_valid", {31'b0, rsp_valid}, 0);
    check("load_e1_ready", {31'b0, cmd_ready}, 0);
    @(posedge clk);
    check("load_e2_valid", {31'b0, rsp_valid}, 1);
    check("load_e2_data", {28'b0, rsp_data}, 4'b1011);
    check("load_e2_ready", {31'b0, cmd_ready}, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    rsp_ready = 1'b0;
    check("load_hs_ready", {31'b0, cmd_ready}, 1);
    check("load_hs_valid", {31'b0, rsp_valid}, 0);

    // Stray rsp_ready while idle has no effect
    rsp_ready = 1'b1;
    @(posedge clk);
    rsp_ready = 1'b0;
    check("stray_rdy_ready", {31'b0, cmd_ready}, 1);
    check("stray_rdy_sr_o", {28'b0, sr_o}, 4'b1011);

    // 1011 >> 2 with fill 0 = 0010
    run_cmd("shr2", 2'b01, 4'b0000, 3'd2, 1'b0, 2'b01, 2, 4'b0010);
    run_cmd("reload1", 2'b00, 4'b1011, 3'd0, 1'b0, 2'b11, 1, 4'b1011);
    // 1011 << 1 with fill 1 = 0111
    run_cmd("shl1", 2'b10, 4'b0000, 3'd1, 1'b1, 2'b10, 1, 4'b0111);
    // Seven right shifts of fill 1 leave all ones
    run_cmd("shr7", 2'b01, 4'b0000, 3'd7, 1'b1, 2'b01, 7, 4'b1111);
    run_cmd("reload2", 2'b00, 4'b1011, 3'd0, 1'b0, 2'b11, 1, 4'b1011);
    // ROR by 5 on a 4-bit value equals ROR by 1: 1011 -> 1101
    run_cmd("ror5", 2'b11, 4'b0000, 3'd5, 1'b0, 2'b01, 5, 4'b1101);

    // SHR by zero: response after E1, held while rsp_ready stays low
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_cnt   = 3'd0;
    cmd_fill  = 1'b1;
    @(posedge clk);
    cmd_valid = 1'b0;
    check("shr0_e0_sr_s", {30'b0, sr_s}, 2'b00);
    check("shr0_e0_valid", {31'b0, rsp_valid}, 0);
    @(posedge clk);
    check("shr0_e1_valid", {31'b0, rsp_valid}, 1);
    // Offer a LOAD while busy; it must be ignored
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      check("shr0_hold_sr_s", {30'b0, sr_s}, 2'b00);
      check("shr0_hold_valid", {31'b0, rsp_valid}, 1);
      check("shr0_hold_data", {28'b0, rsp_data}, 4'b1101);
      check("shr0_hold_ready", {31'b0, cmd_ready}, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    rsp_ready = 1'b0;
    check("shr0_hs_ready", {31'b0, cmd_ready}, 1);
    check("shr0_hs_sr_o", {28'b0, sr_o}, 4'b1101);
    @(posedge clk);
    check("shr0_after_busy", {31'b0, busy}, 0);

    // Reset in the middle of SHR by 6, after two steps
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_cnt   = 3'd6;
    cmd_fill  = 1'b0;
    @(posedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    check("midrst_busy_before", {31'b0, busy}, 1);
    check("midrst_cnt_before", {29'b0, dut.step_cnt}, 4);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    reset = 1'b0;
    @(posedge clk);
    run_cmd("load0101", 2'b00, 4'b0101, 3'd0, 1'b0, 2'b11, 1, 4'b0101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
